// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
package loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FINISH = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // End-of-image word (halt instruction).
    localparam logic [31:0] DEFAULT_TERMINATOR = 32'hFFFF_FFFF;

endpackage

// File: rtl/le_word_assembler.sv
// Little-endian 4-byte packer. Holds the bytes of the word being streamed and
// flags when the incoming byte completes a word equal to TERMINATOR.
module le_word_assembler
    import loader_pkg::*;
#(
    parameter logic [31:0] TERMINATOR = DEFAULT_TERMINATOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byteIn,
    input  logic [1:0]  lane,
    output logic [31:0] word,
    output logic        wordMatch
);

    logic [31:0] r_word;
    logic [31:0] w_merged;

    // Capture the accepted byte into its lane; a new load starts from a clean word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_word <= '0;
        end else if (shift) begin
            case (lane)
                2'd0:    r_word[7:0]   <= byteIn;
                2'd1:    r_word[15:8]  <= byteIn;
                2'd2:    r_word[23:16] <= byteIn;
                default: r_word[31:24] <= byteIn;
            endcase
        end
    end

    // Present the word as it will look once the current byte lands in its lane.
    always_comb begin
        w_merged = r_word;
        case (lane)
            2'd0:    w_merged[7:0]   = byteIn;
            2'd1:    w_merged[15:8]  = byteIn;
            2'd2:    w_merged[23:16] = byteIn;
            default: w_merged[31:24] = byteIn;
        endcase
    end

    assign word = w_merged;
    // Only meaningful when the current byte is the top lane; the caller qualifies it.
    assign wordMatch = ({byteIn, r_word[23:0]} == TERMINATOR);

endmodule

// File: rtl/instruction_loader.sv
// Streams boot bytes into the instruction memory byte port and keeps the core
// in reset until an aligned terminator word has been written.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | waiting for start, core held
//  ST_LOAD   | accepting bytes, one registered write per accepted byte
//  ST_FINISH | carries the write of the last terminator byte
//  ST_DONE   | image loaded, core released
//  ST_ERROR  | memory exhausted without terminator, core held
module instruction_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MEM_BYTES  = 65536,
    parameter logic [31:0] TERMINATOR = DEFAULT_TERMINATOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic        memWriteEnable,
    output logic [31:0] memWriteAddress,
    output logic [7:0]  memWriteData,
    output logic        cpuHold,
    output logic        done,
    output logic        error,
    output logic [31:0] byteCount
);

    localparam int OW = $clog2(MEM_BYTES);
    localparam logic [OW-1:0] LAST_OFFSET = OW'(MEM_BYTES - 1);

    state_t         r_state;
    logic [OW-1:0]  r_offset;
    logic [31:0]    r_count;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [7:0]     r_data;

    logic           w_accept;
    logic           w_restart;
    logic           w_term;
    logic           w_word_match;
    logic [31:0]    w_word;
    logic [1:0]     w_lane;
    logic [7:0]     w_lane_byte;

    assign w_lane    = r_offset[1:0];
    assign byteReady = (r_state == ST_LOAD);
    assign w_accept  = byteValid && byteReady;
    assign w_restart = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERROR));
    assign w_term    = w_accept && (w_lane == 2'd3) && w_word_match;

    assign done    = (r_state == ST_DONE);
    assign error   = (r_state == ST_ERROR);
    assign cpuHold = (r_state != ST_DONE);

    assign memWriteEnable  = r_we;
    assign memWriteAddress = r_addr;
    assign memWriteData    = r_data;
    assign byteCount       = r_count;

    le_word_assembler #(
        .TERMINATOR (TERMINATOR)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_restart),
        .shift     (w_accept),
        .byteIn    (byteIn),
        .lane      (w_lane),
        .word      (w_word),
        .wordMatch (w_word_match)
    );

    // The written byte is taken from the assembler's lane so memory and matcher see the same word.
    always_comb begin
        w_lane_byte = 8'h00;
        case (w_lane)
            2'd0:    w_lane_byte = w_word[7:0];
            2'd1:    w_lane_byte = w_word[15:8];
            2'd2:    w_lane_byte = w_word[23:16];
            default: w_lane_byte = w_word[31:24];
        endcase
    end

    // Sequencing: terminator takes precedence over exhaustion on the last byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: if (start) r_state <= ST_LOAD;
                ST_LOAD: begin
                    if (w_term)
                        r_state <= ST_FINISH;
                    else if (w_accept && (r_offset == LAST_OFFSET))
                        r_state <= ST_ERROR;
                end
                ST_FINISH: r_state <= ST_DONE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Offset and byte counter; the offset saturates at the last location instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_offset <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 32'd1;
            if (r_offset != LAST_OFFSET)
                r_offset <= r_offset + 1'b1;
        end
    end

    // Registered memory write port: one strobe the cycle after each accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_addr <= BASE_ADDR;
            r_data <= 8'h00;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr <= BASE_ADDR + 32'(r_offset);
                r_data <= w_lane_byte;
            end
        end
    end

endmodule
